apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
//  Parametrised APB master: accepts one command at a time on a valid/ready request port.
//  Runs the APB SETUP/ACCESS phases toward NUM_SLV slaves, with one-hot psel decoded from paddr.
//  Returns read data plus a 2-bit status on a valid/ready response port.
//  Sits between the test/CPU-side sequencer and the SPI controller's APB register slave (and peers).
// PARAMETERS
//  ADDR_W      32   paddr width (bits)
//  DATA_W      32   pwdata/prdata width (bits)
//  NUM_SLV     3    number of APB slaves = psel width; legal range 2..16
//  SEL_W       $clog2(NUM_SLV)  slave index field = paddr[ADDR_W-1 -: SEL_W] (derived, not overridden)
//  TIMEOUT_CYC 16   ACCESS-phase cycles before abort (used only with APB_TIMEOUT_EN)
// PORTS
//  clk        in   1        clock, all logic on posedge
//  rst        in   1        synchronous, active-high reset
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        bridge can accept command
//  cmd_write  in   1        1=write, 0=read
//  cmd_addr   in   ADDR_W   target address
//  cmd_wdata  in   DATA_W   write data
//  rsp_valid  out  1        response present
//  rsp_ready  in   1        response consumed
//  rsp_rdata  out  DATA_W   read data (0 on writes/errors)
//  rsp_status out  2        00 OK, 01 slave perror, 10 decode error, 11 timeout
//  psel       out  NUM_SLV  one-hot slave select
//  penable    out  1        APB enable
//  pwrite     out  1        APB direction
//  paddr      out  ADDR_W   APB address
//  pwdata     out  DATA_W   APB write data
//  prdata     in   DATA_W   APB read data
//  pready     in   1        APB ready (wait states allowed)
//  perror     in   1        APB slave error, valid with pready
// BEHAVIOUR
//  Reset:
//   - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
//   - rsp_valid=0, rsp_rdata=0, rsp_status=00, cmd_ready=1, state=IDLE.
//   - All outputs are registered.
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE:
//   - IDLE: cmd_ready=1. On cmd_valid&cmd_ready (edge T), latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata.
//     Set cmd_ready=0. idx<NUM_SLV -> SETUP; idx>=NUM_SLV -> RESP with status 10, no psel (decode error).
//   - SETUP (cycle T+1): psel[idx]=1, penable=0. Unconditionally -> ACCESS.
//   - ACCESS (T+2 onward): psel held, penable=1, paddr/pwrite/pwdata stable.
//     Edge with pready=1: capture rsp_rdata=prdata on reads (0 on writes) and status=perror?01:00.
//     Then psel=0, penable=0, -> RESP. pready=0 holds ACCESS (wait state).
//   - RESP: rsp_valid=1, data/status stable until rsp_ready=1. On handshake, rsp_valid=0, cmd_ready=1 -> IDLE.
//     Next command is accepted no earlier than the following edge.
//  Latency:
//   - Zero-wait transfer: command accept to rsp_valid = 3 cycles. Each wait state adds 1.
//   - Decode error: 1 cycle.
//  Invariants:
//   - At most one psel bit is high.
//   - penable=1 only if psel!=0.
//   - cmd_ready and rsp_valid are never both 1.
//  Boundaries:
//   - perror is ignored when pready=0.
//   - cmd_valid is ignored while cmd_ready=0.
//   - rsp_ready while rsp_valid=0 has no effect.
//   - rst mid-transfer: psel/penable drop at that edge, transfer is abandoned, no response is issued.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//   - 5-bit-min counter clears on entry to ACCESS and increments per ACCESS cycle with pready=0.
//   - When it reaches TIMEOUT_CYC-1 with pready still 0, the next edge aborts: psel=0, penable=0, rsp_rdata=0, status 11 -> RESP.
//   - pready=1 on the terminal cycle wins over timeout.
//  APB_TIMEOUT_EN undefined:
//   - No counter; ACCESS waits indefinitely; status 11 is never produced.
// TESTING
//  1 Write 0x0000_0004 data 0xA5A5_5A5A to slave 0, pready=1 at once
//    -> psel=001 at T+1, penable at T+2, rsp_valid at T+3, status 00, rsp_rdata=0.
//  2 Read paddr idx 2, slave holds pready=0 for 3 cycles, prdata=0x1234_5678
//    -> penable high 4 cycles, rsp_rdata=0x1234_5678, status 00, rsp_valid at T+6.
//  3 Write to idx 1 with pready=1, perror=1 -> status 01. perror=1 with pready=0 earlier -> ignored.
//  4 Command with idx 3 (NUM_SLV=3) -> psel stays 000, rsp_valid at T+1, status 10.
//  5 APB_TIMEOUT_EN, TIMEOUT_CYC=16, pready stuck 0 -> abort after 16 ACCESS cycles, status 11.
//    Without macro: still in ACCESS after 100 cycles.
//  6 Assert rst in ACCESS -> next edge psel=0, penable=0, cmd_ready=1, no rsp_valid.
//    Hold rsp_ready=0 in RESP for 5 cycles -> response stable, cmd_valid ignored.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB master with valid/ready command
// and response ports. The slave index is the top SEL_W bits of the address;
// indices at or above NUM_SLV complete at once with a decode error.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SLV     = 3,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic [NUM_SLV-1:0] psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              perror
);

  localparam int unsigned SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_SLVERR  = 2'b01;
  localparam logic [1:0] ST_DECERR  = 2'b10;
`ifdef APB_TIMEOUT_EN
  localparam logic [1:0] ST_TIMEOUT = 2'b11;
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYC) + 1 > 5) ? $clog2(TIMEOUT_CYC) + 1 : 5;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              state_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_status_q;
  logic [NUM_SLV-1:0]  psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;

  logic [SEL_W-1:0]    cmd_idx;
  logic                idx_ok;
  logic [NUM_SLV-1:0]  psel_d;

`ifdef APB_TIMEOUT_EN
  logic [TO_W-1:0]     to_cnt_q;
`else
  logic [31:0]         unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
`endif

  // Decode the slave select for the command being offered
  always_comb begin
    cmd_idx = cmd_addr[ADDR_W-1 -: SEL_W];
    idx_ok  = (32'(cmd_idx) < NUM_SLV);
    psel_d  = {{(NUM_SLV-1){1'b0}}, 1'b1} << cmd_idx;
  end

  // Transfer sequencer; every port is driven straight from a register here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= ST_OK;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            if (idx_ok) begin
              // psel is raised on the accept edge so SETUP is visible the next cycle
              psel_q  <= psel_d;
              state_q <= S_SETUP;
            end else begin
              rsp_rdata_q  <= '0;
              rsp_status_q <= ST_DECERR;
              rsp_valid_q  <= 1'b1;
              state_q      <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
          to_cnt_q  <= '0;
`endif
        end
        S_ACCESS: begin
          if (pready) begin
            psel_q       <= '0;
            penable_q    <= 1'b0;
            rsp_rdata_q  <= pwrite_q ? '0 : prdata;
            rsp_status_q <= perror ? ST_SLVERR : ST_OK;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            psel_q       <= '0;
            penable_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= ST_TIMEOUT;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;

endmodule
